// File: rtl/stream_fifo_arbiter.sv
// Round-robin burst scheduler sharing one FIFO input port between NUM_IN streams.
// A producer is granted a BURST-beat window only when the FIFO has room for all of it.
module stream_fifo_arbiter #(
  parameter int NUM_IN  = 4,
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 512,
  parameter int CNT_W   = 10,
  parameter int BURST   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_V_TDATA,
  input  logic [NUM_IN-1:0]       in_V_TVALID,
  output logic [NUM_IN-1:0]       in_V_TREADY,
  output logic [WIDTH-1:0]        out_V_TDATA,
  output logic                    out_V_TVALID,
  input  logic                    out_V_TREADY,
  input  logic [CNT_W-1:0]        fifo_count,
  output logic [NUM_IN-1:0]       grant,
  output logic                    busy,
  output logic                    early_release
);

  localparam int IDX_W  = $clog2(NUM_IN);
  localparam int BEAT_W = $clog2(BURST + 1);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W:0]      DEPTH_C    = (CNT_W+1)'(DEPTH);
  localparam logic [CNT_W:0]      BURST_C    = (CNT_W+1)'(BURST);
  localparam logic [BEAT_W-1:0]   LAST_BEAT  = BEAT_W'(BURST - 1);
  localparam logic [IDLE_W-1:0]   IDLE_LIMIT = IDLE_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0]    LAST_INIT  = IDX_W'(NUM_IN - 1);
  localparam logic [NUM_IN-1:0]   ONE_HOT0   = NUM_IN'(1);

  typedef enum logic [1:0] {
    ST_ARB,
    ST_BURST,
    ST_GAP
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [IDX_W-1:0]    g_idx;
  logic [IDX_W-1:0]    last;
  logic [IDX_W-1:0]    pick_idx;
  logic [IDX_W-1:0]    cand;
  logic                pick_found;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [IDLE_W-1:0]   idle_cnt;
  logic [CNT_W:0]      free;
  logic [WIDTH-1:0]    sel_data;
  logic                start;
  logic                g_valid;
  logic                beat;
  logic                final_beat;
  logic                timeout;

  // Extra bit keeps the subtraction unsigned and wide enough to hold DEPTH itself.
  assign free       = DEPTH_C - {1'b0, fifo_count};
  assign start      = pick_found && (free >= BURST_C);
  assign g_valid    = in_V_TVALID[g_idx];
  assign beat       = (state == ST_BURST) && g_valid && out_V_TREADY;
  assign final_beat = beat && (beat_cnt == LAST_BEAT);
  assign timeout    = (state == ST_BURST) && !g_valid && (idle_cnt == IDLE_LIMIT);

  // Round-robin search starting just after the previous owner.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= NUM_IN; k++) begin
      cand = IDX_W'((int'(last) + k) % NUM_IN);
      if (!pick_found && in_V_TVALID[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (g_idx == IDX_W'(i)) sel_data = in_V_TDATA[i*WIDTH +: WIDTH];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) state <= ST_ARB;
    else           state <= state_nxt;
  end

  // NOTE: every output of a combinational process gets a default first so no
  // path through the case leaves it unassigned (which would infer a latch).
  always_comb begin
    state_nxt = state;
    case (state)
      ST_ARB:   if (start) state_nxt = ST_BURST;
      ST_BURST: if (final_beat || timeout) state_nxt = ST_GAP;
      ST_GAP:   state_nxt = ST_ARB;
      default:  state_nxt = ST_ARB;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      g_idx    <= '0;
      last     <= LAST_INIT;
      grant    <= '0;
      beat_cnt <= '0;
      idle_cnt <= '0;
    end else if (state == ST_ARB && start) begin
      g_idx    <= pick_idx;
      last     <= pick_idx;
      grant    <= ONE_HOT0 << pick_idx;
      beat_cnt <= '0;
      idle_cnt <= '0;
    end else if (state == ST_BURST) begin
      // Counters stop on the exit edge, so neither can wrap past its limit.
      if (final_beat || timeout) begin
        grant <= '0;
      end else if (beat) begin
        beat_cnt <= beat_cnt + BEAT_W'(1);
        idle_cnt <= '0;
      end else if (!g_valid) begin
        idle_cnt <= idle_cnt + IDLE_W'(1);
      end
    end
  end

  always_comb begin
    in_V_TREADY   = '0;
    out_V_TVALID  = 1'b0;
    out_V_TDATA   = '0;
    busy          = 1'b0;
    early_release = 1'b0;
    if (state == ST_BURST) begin
      in_V_TREADY[g_idx] = out_V_TREADY;
      out_V_TVALID       = g_valid;
      out_V_TDATA        = sel_data;
      busy               = 1'b1;
      // A completing beat takes priority over the watchdog.
      early_release      = timeout && !final_beat;
    end
  end

endmodule

// File: tb/tb_stream_fifo_arbiter.sv
// Bench for stream_fifo_arbiter: a vector table for grant/space decisions plus
// scoreboarded sequences for rotation, timeout, back-pressure, reset and boundary.
module tb_stream_fifo_arbiter;

  localparam int NUM_IN  = 4;
  localparam int WIDTH   = 8;
  localparam int DEPTH   = 512;
  localparam int CNT_W   = 10;
  localparam int BURST   = 16;
  localparam int TIMEOUT = 64;

  logic                    ap_clk;
  logic                    ap_rst_n;
  logic [NUM_IN*WIDTH-1:0] in_V_TDATA;
  logic [NUM_IN-1:0]       in_V_TVALID;
  logic [NUM_IN-1:0]       in_V_TREADY;
  logic [WIDTH-1:0]        out_V_TDATA;
  logic                    out_V_TVALID;
  logic                    out_V_TREADY;
  logic [CNT_W-1:0]        fifo_count;
  logic [NUM_IN-1:0]       grant;
  logic                    busy;
  logic                    early_release;

  stream_fifo_arbiter #(
    .NUM_IN(NUM_IN), .WIDTH(WIDTH), .DEPTH(DEPTH),
    .CNT_W(CNT_W), .BURST(BURST), .TIMEOUT(TIMEOUT)
  ) dut (
    .ap_clk        (ap_clk),
    .ap_rst_n      (ap_rst_n),
    .in_V_TDATA    (in_V_TDATA),
    .in_V_TVALID   (in_V_TVALID),
    .in_V_TREADY   (in_V_TREADY),
    .out_V_TDATA   (out_V_TDATA),
    .out_V_TVALID  (out_V_TVALID),
    .out_V_TREADY  (out_V_TREADY),
    .fifo_count    (fifo_count),
    .grant         (grant),
    .busy          (busy),
    .early_release (early_release)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [NUM_IN-1:0] grant;
    logic [WIDTH-1:0]  data;
  } exp_t;

  typedef struct {
    logic [CNT_W-1:0]  cnt;
    logic [NUM_IN-1:0] valid;
    logic [NUM_IN-1:0] exp_grant;
    logic [WIDTH-1:0]  exp_data;
  } vec_t;

  exp_t              sb[$];
  exp_t              tmp;
  vec_t              vecs[9];
  int                order[5] = '{0, 1, 2, 3, 0};
  int                sq[NUM_IN];
  int                checks = 0;
  int                errors = 0;
  int                seen   = 0;
  int                idle_k;
  int                first_cyc;
  bit                beat;

  // Producer model: stream i sends {i, seq} and stops once seq reaches lim[i].
  logic [5:0]        pdata[NUM_IN];
  int                lim[NUM_IN];
  logic [NUM_IN-1:0] en;
  logic [NUM_IN-1:0] fire_q;
  logic              rst;
  logic              rdy;
  logic [CNT_W-1:0]  cnt;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "bench time limit");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_inputs();
    ap_rst_n     = rst;
    out_V_TREADY = rdy;
    fifo_count   = cnt;
    for (int i = 0; i < NUM_IN; i++) begin
      in_V_TVALID[i]              = en[i] && (int'(pdata[i]) < lim[i]);
      in_V_TDATA[i*WIDTH +: WIDTH] = {2'(i), pdata[i]};
    end
  endtask

  task automatic push_beats(input int s, input int first, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.grant = NUM_IN'(1) << s;
      e.data  = {2'(s), 6'(first + k)};
      sb.push_back(e);
    end
  endtask

  // One clock: inputs change just after the rising edge, outputs are sampled
  // and beats scoreboarded on the falling edge.
  task automatic cycle();
    exp_t e;
    @(posedge ap_clk);
    #1;
    for (int i = 0; i < NUM_IN; i++) if (fire_q[i]) pdata[i] = pdata[i] + 6'd1;
    drive_inputs();
    @(negedge ap_clk);
    fire_q = in_V_TVALID & in_V_TREADY;
    beat   = out_V_TVALID && out_V_TREADY;
    if (beat) begin
      seen++;
      check("sb_has_entry", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("beat_data", 32'(out_V_TDATA), 32'(e.data));
        check("beat_grant", 32'(grant), 32'(e.grant));
      end
    end
  endtask

  task automatic run_until(input int target, input string name);
    int n = 0;
    while (seen < target && n < 200) begin
      cycle();
      n++;
    end
    check({name, "_beats"}, 32'(seen), 32'(target));
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    en  = '0;
    rdy = 1'b1;
    cnt = '0;
    for (int i = 0; i < NUM_IN; i++) lim[i] = 0;
    cycle();
    cycle();
    rst    = 1'b1;
    fire_q = '0;
    seen   = 0;
    sb.delete();
    for (int i = 0; i < NUM_IN; i++) pdata[i] = '0;
  endtask

  initial begin
    vecs[0] = '{cnt: 10'd0,   valid: 4'b0001, exp_grant: 4'b0001, exp_data: 8'h00};
    vecs[1] = '{cnt: 10'd0,   valid: 4'b0100, exp_grant: 4'b0100, exp_data: 8'h80};
    vecs[2] = '{cnt: 10'd497, valid: 4'b0100, exp_grant: 4'b0000, exp_data: 8'h00};
    vecs[3] = '{cnt: 10'd496, valid: 4'b0100, exp_grant: 4'b0100, exp_data: 8'h80};
    vecs[4] = '{cnt: 10'd512, valid: 4'b1111, exp_grant: 4'b0000, exp_data: 8'h00};
    vecs[5] = '{cnt: 10'd0,   valid: 4'b1010, exp_grant: 4'b0010, exp_data: 8'h40};
    vecs[6] = '{cnt: 10'd0,   valid: 4'b1000, exp_grant: 4'b1000, exp_data: 8'hC0};
    vecs[7] = '{cnt: 10'd0,   valid: 4'b0000, exp_grant: 4'b0000, exp_data: 8'h00};
    vecs[8] = '{cnt: 10'd496, valid: 4'b0110, exp_grant: 4'b0010, exp_data: 8'h40};

    // Reset state with every producer requesting.
    rst = 1'b0; en = '1; rdy = 1'b1; cnt = '0; fire_q = '0;
    for (int i = 0; i < NUM_IN; i++) begin lim[i] = 100; pdata[i] = '0; end
    drive_inputs();
    cycle();
    cycle();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_early_release", 32'(early_release), 32'd0);
    check("rst_tready", 32'(in_V_TREADY), 32'd0);
    check("rst_tvalid", 32'(out_V_TVALID), 32'd0);
    check("rst_tdata", 32'(out_V_TDATA), 32'd0);
    rst = 1'b1;
    push_beats(0, 0, 1);
    cycle();
    check("first_pre_grant", 32'(grant), 32'd0);
    cycle();
    check("first_priority", 32'(grant), 32'b0001);

    // Single-edge arbitration decisions from the vector table.
    foreach (vecs[i]) begin
      apply_reset();
      cnt = vecs[i].cnt;
      en  = vecs[i].valid;
      for (int j = 0; j < NUM_IN; j++) lim[j] = 100;
      if (vecs[i].exp_grant != '0) begin
        tmp.grant = vecs[i].exp_grant;
        tmp.data  = vecs[i].exp_data;
        sb.push_back(tmp);
      end
      cycle();
      check($sformatf("vec%0d_pre_grant", i), 32'(grant), 32'd0);
      cycle();
      check($sformatf("vec%0d_grant", i), 32'(grant), 32'(vecs[i].exp_grant));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_grant != '0));
      check($sformatf("vec%0d_tready", i), 32'(in_V_TREADY), 32'(vecs[i].exp_grant));
      check($sformatf("vec%0d_tvalid", i), 32'(out_V_TVALID), 32'(vecs[i].exp_grant != '0));
      check($sformatf("vec%0d_tdata", i), 32'(out_V_TDATA), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d_sb_empty", i), 32'(sb.size()), 32'd0);
    end

    // Fair rotation: grants 0,1,2,3,0, 16 ordered beats each, one burst per BURST+2 cycles.
    apply_reset();
    en = '1;
    for (int i = 0; i < NUM_IN; i++) begin lim[i] = 100; sq[i] = 0; end
    for (int r = 0; r < 5; r++) begin
      push_beats(order[r], sq[order[r]], BURST);
      sq[order[r]] += BURST;
    end
    first_cyc = -1;
    for (int c = 0; c < 300 && sb.size() > 0; c++) begin
      cycle();
      if (beat && (seen % BURST) == 1) begin
        if (first_cyc >= 0) check("burst_period", 32'(c - first_cyc), 32'(BURST + 2));
        first_cyc = c;
      end
    end
    check("rotation_drained", 32'(sb.size()), 32'd0);
    check("rotation_beats", 32'(seen), 32'd80);

    // Space gating: free = 15 blocks the grant; free = 16 allows it on the next edge.
    apply_reset();
    cnt = 10'd497; en = 4'b0100; rdy = 1'b0;
    for (int i = 0; i < NUM_IN; i++) lim[i] = 100;
    for (int k = 0; k < 6; k++) begin
      cycle();
      check("gate_no_grant", 32'(grant), 32'd0);
    end
    cnt = 10'd496;
    cycle();
    check("gate_before_edge", 32'(grant), 32'd0);
    cycle();
    check("gate_grant", 32'(grant), 32'b0100);
    check("gate_busy", 32'(busy), 32'd1);
    check("gate_tvalid", 32'(out_V_TVALID), 32'd1);
    check("gate_tready_blocked", 32'(in_V_TREADY), 32'd0);

    // Timeout: stream 1 sends 5 beats then idles; pulse exactly on the 64th idle cycle.
    apply_reset();
    en = 4'b0010; lim[1] = 5;
    push_beats(1, 0, 5);
    idle_k = 0;
    for (int c = 0; c < 150 && idle_k < 66; c++) begin
      cycle();
      if (!beat && seen == 5) idle_k++;
      check("to_early_release", 32'(early_release), 32'(seen == 5 && idle_k == TIMEOUT));
      if (idle_k == TIMEOUT + 1) begin
        check("to_gap_busy", 32'(busy), 32'd0);
        check("to_gap_grant", 32'(grant), 32'd0);
        check("to_gap_tready", 32'(in_V_TREADY), 32'd0);
      end
      if (idle_k == TIMEOUT + 2) check("to_arb_busy", 32'(busy), 32'd0);
    end
    check("to_idle_cycles", 32'(idle_k), 32'd66);
    check("to_sb_empty", 32'(sb.size()), 32'd0);

    // Back-pressure: 100 stalled cycles with valid high neither time out nor count beats.
    apply_reset();
    en = 4'b0001; lim[0] = 100;
    push_beats(0, 0, BURST);
    run_until(5, "bp_pre");
    rdy = 1'b0;
    for (int k = 0; k < 100; k++) begin
      cycle();
      check("bp_stall_release", 32'(early_release), 32'd0);
      check("bp_stall_busy", 32'(busy), 32'd1);
    end
    rdy = 1'b1;
    run_until(BURST, "bp_post");
    cycle();
    check("bp_end_busy", 32'(busy), 32'd0);
    check("bp_end_tvalid", 32'(out_V_TVALID), 32'd0);
    check("bp_sb_empty", 32'(sb.size()), 32'd0);

    // Reset at beat 7 of stream 1; afterwards stream 0 has priority again.
    apply_reset();
    en = 4'b0010;
    for (int i = 0; i < NUM_IN; i++) lim[i] = 100;
    push_beats(1, 0, 7);
    run_until(7, "mid_pre");
    rst = 1'b0; en = 4'b0101; rdy = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    check("mid_rst_grant", 32'(grant), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_tready", 32'(in_V_TREADY), 32'd0);
    check("mid_rst_tvalid", 32'(out_V_TVALID), 32'd0);
    cycle();
    check("mid_next_grant", 32'(grant), 32'b0001);
    check("mid_sb_empty", 32'(sb.size()), 32'd0);

    // Boundary: 16th beat arrives on the cycle the idle watchdog would expire.
    apply_reset();
    en = 4'b0001; lim[0] = 15;
    push_beats(0, 0, BURST);
    run_until(15, "bnd_pre");
    for (int k = 1; k < TIMEOUT; k++) begin
      cycle();
      check("bnd_idle_release", 32'(early_release), 32'd0);
      check("bnd_idle_busy", 32'(busy), 32'd1);
    end
    lim[0] = 16;
    cycle();
    check("bnd_final_beat", 32'(beat), 32'd1);
    check("bnd_final_release", 32'(early_release), 32'd0);
    cycle();
    check("bnd_end_busy", 32'(busy), 32'd0);
    check("bnd_end_release", 32'(early_release), 32'd0);
    check("bnd_beats", 32'(seen), 32'(BURST));
    check("bnd_sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
